// File: rtl/gppcu_mc_intu.sv
// gppcu_mc_intu: iterative integer multiply/divide unit, one shift step per enabled clock.
// Build option: define GPPCU_MC_INTU_SIGNED_EN to make MULHS, DIVS and REMS signed.

module gppcu_mc_intu #(
    parameter int BW = 32
) (
    input  logic          iACLK,
    input  logic          inRST,
    input  logic          iCLKEN,
    input  logic          iSTART,
    input  logic [BW-1:0] iDA,
    input  logic [BW-1:0] iDB,
    input  logic [2:0]    iN,
    output logic          oBUSY,
    output logic          oDONE,
    output logic [BW-1:0] oQ
);

    localparam int CW = $clog2(BW);

    localparam logic [2:0] OP_MULLO = 3'd0;
    localparam logic [2:0] OP_MULHU = 3'd1;
    localparam logic [2:0] OP_MULHS = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_REMU  = 3'd4;
    localparam logic [2:0] OP_DIVS  = 3'd5;
    localparam logic [2:0] OP_REMS  = 3'd6;

    localparam logic [BW-1:0] ZERO = {BW{1'b0}};
    localparam logic [BW-1:0] ONES = {BW{1'b1}};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t        state_r;
    state_t        state_s;
    logic [CW-1:0] cnt_r;
    logic [2:0]    op_r;
    logic [BW-1:0] a_r;
    logic [BW-1:0] b_r;
    logic [BW-1:0] m_r;
    logic [BW-1:0] acc_r;
    logic [BW-1:0] lo_r;
    logic [BW-1:0] q_r;
    logic          busy_r;
    logic          done_r;

    logic [2:0]    start_op_s;
    logic          start_mul_s;
    logic [BW-1:0] dvd_s;
    logic [BW-1:0] dvs_s;
    logic          run_mul_s;
    logic [BW:0]   sum_s;
    logic [BW:0]   trial_s;
    logic [BW-1:0] acc_nx_s;
    logic [BW-1:0] lo_nx_s;
    logic          dz_s;
    logic [BW-1:0] q_fix_s;
    logic [BW-1:0] q_s;
    logic          busy_s;
    logic          done_s;

    // Without the signed option the signed opcodes collapse onto their unsigned twins.
    function automatic logic [2:0] norm_op_f(input logic [2:0] op);
`ifdef GPPCU_MC_INTU_SIGNED_EN
        norm_op_f = op;
`else
        case (op)
            OP_MULHS: norm_op_f = OP_MULHU;
            OP_DIVS:  norm_op_f = OP_DIVU;
            OP_REMS:  norm_op_f = OP_REMU;
            default:  norm_op_f = op;
        endcase
`endif
    endfunction

`ifdef GPPCU_MC_INTU_SIGNED_EN
    function automatic logic [BW-1:0] neg_f(input logic [BW-1:0] x);
        neg_f = ZERO - x;
    endfunction
`endif

    // Operand conditioning at start: signed divides iterate on magnitudes.
    always_comb begin
        start_op_s  = norm_op_f(iN);
        start_mul_s = (start_op_s <= OP_MULHS);
`ifdef GPPCU_MC_INTU_SIGNED_EN
        if (((start_op_s == OP_DIVS) || (start_op_s == OP_REMS)) && iDA[BW-1]) begin
            dvd_s = neg_f(iDA);
        end else begin
            dvd_s = iDA;
        end
        if (((start_op_s == OP_DIVS) || (start_op_s == OP_REMS)) && iDB[BW-1]) begin
            dvs_s = neg_f(iDB);
        end else begin
            dvs_s = iDB;
        end
`else
        dvd_s = iDA;
        dvs_s = iDB;
`endif
    end

    // One iteration: shift-add for multiply, restoring shift-subtract for divide.
    always_comb begin
        run_mul_s = (op_r <= OP_MULHS);
        sum_s     = {1'b0, acc_r} + (lo_r[0] ? {1'b0, m_r} : {1'b0, ZERO});
        trial_s   = {acc_r, lo_r[BW-1]} - {1'b0, m_r};
        if (run_mul_s) begin
            acc_nx_s = sum_s[BW:1];
            lo_nx_s  = {sum_s[0], lo_r[BW-1:1]};
        end else if (!trial_s[BW]) begin
            acc_nx_s = trial_s[BW-1:0];
            lo_nx_s  = {lo_r[BW-2:0], 1'b1};
        end else begin
            acc_nx_s = {acc_r[BW-2:0], lo_r[BW-1]};
            lo_nx_s  = {lo_r[BW-2:0], 1'b0};
        end
    end

    // Result selection and sign fix-up; MULHS corrects the unsigned high word.
    always_comb begin
        dz_s = (b_r == ZERO);
        case (op_r)
            OP_MULLO: q_fix_s = lo_r;
            OP_MULHU: q_fix_s = acc_r;
            OP_DIVU:  q_fix_s = dz_s ? ONES : lo_r;
            OP_REMU:  q_fix_s = dz_s ? a_r : acc_r;
`ifdef GPPCU_MC_INTU_SIGNED_EN
            OP_MULHS: q_fix_s = acc_r - (a_r[BW-1] ? b_r : ZERO) - (b_r[BW-1] ? a_r : ZERO);
            OP_DIVS:  q_fix_s = dz_s ? ONES :
                                ((a_r[BW-1] ^ b_r[BW-1]) ? neg_f(lo_r) : lo_r);
            OP_REMS:  q_fix_s = dz_s ? a_r : (a_r[BW-1] ? neg_f(acc_r) : acc_r);
`endif
            default:  q_fix_s = ZERO;
        endcase
    end

    // FSM state register.
    always_ff @(posedge iACLK or negedge inRST) begin
        if (!inRST) begin
            state_r <= ST_IDLE;
        end else if (iCLKEN) begin
            state_r <= state_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (iSTART) begin
                    state_s = ST_RUN;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (cnt_r == {CW{1'b0}}) begin
                    state_s = ST_FIX;
                end else begin
                    state_s = ST_RUN;
                end
            end
            ST_FIX:  state_s = ST_DONE;
            ST_DONE: state_s = ST_IDLE;
            default: state_s = ST_IDLE;
        endcase
    end

    // FSM outputs; the done flag follows DONE by one edge so it lands BW+2 edges after start.
    always_comb begin
        busy_s = (state_s != ST_IDLE);
        done_s = (state_r == ST_DONE);
        if (state_r == ST_FIX) begin
            q_s = q_fix_s;
        end else begin
            q_s = q_r;
        end
    end

    // Operand latch, iteration counter and working registers.
    always_ff @(posedge iACLK or negedge inRST) begin
        if (!inRST) begin
            cnt_r <= {CW{1'b0}};
            op_r  <= 3'd0;
            a_r   <= ZERO;
            b_r   <= ZERO;
            m_r   <= ZERO;
            acc_r <= ZERO;
            lo_r  <= ZERO;
        end else if (iCLKEN) begin
            if ((state_r == ST_IDLE) && iSTART) begin
                cnt_r <= CW'(BW - 1);
                op_r  <= start_op_s;
                a_r   <= iDA;
                b_r   <= iDB;
                m_r   <= start_mul_s ? iDA : dvs_s;
                lo_r  <= start_mul_s ? iDB : dvd_s;
                acc_r <= ZERO;
            end else if (state_r == ST_RUN) begin
                cnt_r <= cnt_r - CW'(1);
                acc_r <= acc_nx_s;
                lo_r  <= lo_nx_s;
            end
        end
    end

    // Registered outputs.
    always_ff @(posedge iACLK or negedge inRST) begin
        if (!inRST) begin
            busy_r <= 1'b0;
            done_r <= 1'b0;
            q_r    <= ZERO;
        end else if (iCLKEN) begin
            busy_r <= busy_s;
            done_r <= done_s;
            q_r    <= q_s;
        end
    end

    assign oBUSY = busy_r;
    assign oDONE = done_r;
    assign oQ    = q_r;

endmodule

// File: tb/tb_gppcu_mc_intu.sv
// Self-checking bench for gppcu_mc_intu (BW=32): spec vectors, corner sequences and random ops.
`timescale 1ns/1ps

module tb_gppcu_mc_intu;

`ifdef GPPCU_MC_INTU_SIGNED_EN
    localparam bit SGN = 1'b1;
`else
    localparam bit SGN = 1'b0;
`endif
    localparam int LAT = 34;

    logic        clk;
    logic        rst_n;
    logic        clken;
    logic        start;
    logic [31:0] da;
    logic [31:0] db;
    logic [2:0]  n;
    logic        busy;
    logic        done;
    logic [31:0] q;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  op;
        logic [31:0] exp_s;
        logic [31:0] exp_u;
        string       name;
    } vec_t;

    vec_t vecs[$];

    gppcu_mc_intu #(.BW(32)) dut (
        .iACLK  (clk),
        .inRST  (rst_n),
        .iCLKEN (clken),
        .iSTART (start),
        .iDA    (da),
        .iDB    (db),
        .iN     (n),
        .oBUSY  (busy),
        .oDONE  (done),
        .oQ     (q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic add_vec(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op,
                           input logic [31:0] exp_s, input logic [31:0] exp_u, input string name);
        vec_t v;
        v.a = a; v.b = b; v.op = op; v.exp_s = exp_s; v.exp_u = exp_u; v.name = name;
        vecs.push_back(v);
    endtask

    // Behavioural reference computed directly from the arithmetic definitions.
    function automatic logic [31:0] model_f(input logic [31:0] a, input logic [31:0] b,
                                            input logic [2:0] op);
        logic [63:0] pu;
        longint      sa;
        longint      sb;
        longint      r;
        logic [2:0]  eop;
        eop = op;
        if (!SGN) begin
            if (op == 3'd2) eop = 3'd1;
            else if (op == 3'd5) eop = 3'd3;
            else if (op == 3'd6) eop = 3'd4;
        end
        pu = {32'h0, a} * {32'h0, b};
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (eop)
            3'd0: return pu[31:0];
            3'd1: return pu[63:32];
            3'd2: begin r = sa * sb; return r[63:32]; end
            3'd3: return (b == 32'h0) ? 32'hFFFF_FFFF : a / b;
            3'd4: return (b == 32'h0) ? a : a % b;
            3'd5: begin
                if (b == 32'h0) return 32'hFFFF_FFFF;
                r = sa / sb;
                return r[31:0];
            end
            3'd6: begin
                if (b == 32'h0) return a;
                r = sa % sb;
                return r[31:0];
            end
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic [31:0] pick_f();
        case ($urandom_range(0, 5))
            0:       return 32'h0;
            1:       return 32'h1;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h8000_0000;
            4:       return 32'($urandom_range(0, 20));
            default: return 32'($urandom);
        endcase
    endfunction

    // Runs one operation; lat counts all clock edges after the start-sampling edge.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op,
                          input int gap_at, input int gap_len, input bit restart,
                          output logic [31:0] res, output int lat, output bit busy_ok);
        @(negedge clk);
        da = a; db = b; n = op; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        da = $urandom; db = $urandom; n = 3'($urandom);
        lat = 0;
        busy_ok = 1'b1;
        while (lat < 200) begin
            if (done) break;
            if (!busy) busy_ok = 1'b0;
            @(negedge clk);
            clken = !((lat >= gap_at) && (lat < gap_at + gap_len));
            start = restart && (lat == 5);
            if (start) begin
                da = 32'd9; db = 32'd9; n = 3'd0;
            end
            @(posedge clk); #1;
            lat++;
        end
        res = q;
        start = 1'b0;
        clken = 1'b1;
    endtask

    initial begin
        logic [31:0] res;
        logic [31:0] exp;
        logic [31:0] ra;
        logic [31:0] rb;
        logic [2:0]  rop;
        int          lat;
        bit          bok;

        add_vec(32'd7,         32'd6,         3'd0, 32'd42,        32'd42,        "mullo_7x6");
        add_vec(32'hFFFF_FFFE, 32'd3,         3'd2, 32'hFFFF_FFFF, 32'h0000_0002, "mulhs_m2x3");
        add_vec(32'hFFFF_FFFE, 32'd3,         3'd1, 32'h0000_0002, 32'h0000_0002, "mulhu_m2x3");
        add_vec(32'hFFFF_FFFF, 32'hFFFF_FFFF, 3'd0, 32'h1,         32'h1,         "mullo_ones");
        add_vec(32'd100,       32'd7,         3'd3, 32'd14,        32'd14,        "divu_100_7");
        add_vec(32'd100,       32'd7,         3'd4, 32'd2,         32'd2,         "remu_100_7");
        add_vec(32'd5,         32'd0,         3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "divu_5_0");
        add_vec(32'd5,         32'd0,         3'd4, 32'd5,         32'd5,         "remu_5_0");
        add_vec(32'hFFFF_FFF9, 32'd2,         3'd5, 32'hFFFF_FFFD, 32'h7FFF_FFFC, "divs_m7_2");
        add_vec(32'hFFFF_FFF9, 32'd2,         3'd6, 32'hFFFF_FFFF, 32'h0000_0001, "rems_m7_2");
        add_vec(32'h8000_0000, 32'hFFFF_FFFF, 3'd5, 32'h8000_0000, 32'h0000_0000, "divs_ovf");
        add_vec(32'h8000_0000, 32'hFFFF_FFFF, 3'd6, 32'h0000_0000, 32'h8000_0000, "rems_ovf");
        add_vec(32'd7,         32'hFFFF_FFFE, 3'd5, 32'hFFFF_FFFD, 32'h0000_0000, "divs_7_m2");
        add_vec(32'hFFFF_FFFB, 32'd0,         3'd6, 32'hFFFF_FFFB, 32'hFFFF_FFFB, "rems_m5_0");
        add_vec(32'd123,       32'd45,        3'd7, 32'h0,         32'h0,         "reserved");

        rst_n = 1'b0; clken = 1'b1; start = 1'b0; da = 32'h0; db = 32'h0; n = 3'd0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_busy", {31'h0, busy}, 32'h0);
        check("reset_done", {31'h0, done}, 32'h0);
        check("reset_q", q, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].op, -1, 0, 1'b0, res, lat, bok);
            check({vecs[i].name, "_q"}, res, SGN ? vecs[i].exp_s : vecs[i].exp_u);
            check({vecs[i].name, "_lat"}, 32'(lat), 32'(LAT));
            check({vecs[i].name, "_busy"}, {31'h0, bok}, 32'h1);
            @(posedge clk); #1;
            check({vecs[i].name, "_pulse"}, {31'h0, done}, 32'h0);
        end

        // Restart request mid-RUN is ignored.
        run_op(32'd100, 32'd7, 3'd3, -1, 0, 1'b1, res, lat, bok);
        check("restart_q", res, 32'd14);
        check("restart_lat", 32'(lat), 32'(LAT));

        // Clock enable low for 5 cycles mid-RUN stretches latency by 5.
        run_op(32'd1000, 32'd3, 3'd3, 10, 5, 1'b0, res, lat, bok);
        check("freeze_run_q", res, 32'd333);
        check("freeze_run_lat", 32'(lat), 32'(LAT + 5));
        check("freeze_run_busy", {31'h0, bok}, 32'h1);

        // Freeze while the done pulse is up keeps it up.
        run_op(32'd5, 32'd5, 3'd0, -1, 0, 1'b0, res, lat, bok);
        clken = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("freeze_done_hold", {31'h0, done}, 32'h1);
        check("freeze_done_q", q, 32'd25);
        clken = 1'b1;
        @(posedge clk); #1;
        check("freeze_done_release", {31'h0, done}, 32'h0);
        check("freeze_done_q_after", q, 32'd25);

        // Asynchronous reset 10 cycles into a DIVU, then a fresh MULLO.
        @(negedge clk);
        da = 32'd1000; db = 32'd3; n = 3'd3; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_busy", {31'h0, busy}, 32'h0);
        check("midrst_done", {31'h0, done}, 32'h0);
        check("midrst_q", q, 32'h0);
        @(posedge clk); #3;
        rst_n = 1'b1;
        run_op(32'd3, 32'd3, 3'd0, -1, 0, 1'b0, res, lat, bok);
        check("postrst_q", res, 32'd9);
        check("postrst_lat", 32'(lat), 32'(LAT));

        // Random operations against the reference model.
        for (int i = 0; i < 60; i++) begin
            ra  = pick_f();
            rb  = pick_f();
            rop = 3'($urandom_range(0, 7));
            exp = model_f(ra, rb, rop);
            run_op(ra, rb, rop, -1, 0, 1'b0, res, lat, bok);
            if (res !== exp) begin
                $display("FAIL rand_%0d op=%0d a=%h b=%h: got %h, expected %h",
                         i, rop, ra, rb, res, exp);
            end
            checks++;
            if (res !== exp) errors++;
            check($sformatf("rand_%0d_lat", i), 32'(lat), 32'(LAT));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/gppcu_mc_intu.md
GPPCU_MC_INTU -- requirements
Module: GPPCU_MC_INTU

Interface
REQ-001 SHALL have parameter BW, default 32, giving the operand and result width (BW >= 4).
REQ-002 SHALL have port iACLK, input, 1 bit: the sole clock, rising-edge.
REQ-003 SHALL have port inRST, input, 1 bit: reset, asynchronous and active-low.
REQ-004 SHALL have port iCLKEN, input, 1 bit: clock enable; when low, all state holds.
REQ-005 SHALL have port iSTART, input, 1 bit: operation request, sampled only in IDLE.
REQ-006 SHALL have port iDA, input, BW bits: operand A (multiplicand or dividend).
REQ-007 SHALL have port iDB, input, BW bits: operand B (multiplier or divisor).
REQ-008 SHALL have port iN, input, 3 bits: opcode.
REQ-009 SHALL have port oBUSY, output, 1 bit: high whenever state is not IDLE.
REQ-010 SHALL have port oDONE, output, 1 bit: single-cycle completion pulse.
REQ-011 SHALL have port oQ, output, BW bits: result.

Function
REQ-012 SHALL decode opcodes as: 0 MULLO, 1 MULHU, 2 MULHS, 3 DIVU, 4 REMU, 5 DIVS, 6 REMS, 7 reserved (result 0).
REQ-013 SHALL implement the FSM states IDLE, RUN, FIX and DONE.
REQ-014 SHALL, in IDLE with iSTART=1 and iCLKEN=1, latch iDA, iDB and iN at the clock edge, load the iteration counter with BW-1, and enter RUN.
REQ-015 SHALL, in RUN, perform one shift-add (multiply) or restoring shift-subtract (divide) step per enabled cycle, and enter FIX after the step taken with counter = 0 (BW steps total).
REQ-016 SHALL, in FIX, apply sign correction and result selection, load oQ, and enter DONE.
REQ-017 SHALL hold oDONE=1 for exactly one enabled cycle in DONE, then return to IDLE.
REQ-018 SHALL give a latency of BW+2 enabled cycles: oDONE is high during the cycle after the (BW+2)th enabled edge following the start-sampling edge.
REQ-019 SHALL hold oQ from FIX until the next FIX; oQ is stable while oDONE=1 and afterwards.
REQ-020 SHALL ignore iSTART in RUN, FIX and DONE; a request held high through DONE is accepted again in IDLE.
REQ-021 SHALL ignore changes on iDA, iDB and iN after the start-sampling edge.
REQ-022 SHALL return low BW bits of the 2*BW-bit product for MULLO, regardless of signedness.
REQ-023 SHALL return the high BW bits of the unsigned product for MULHU and of the two's-complement product for MULHS.
REQ-024 SHALL, on divide by zero, return all ones for DIVU/DIVS and the dividend for REMU/REMS.
REQ-025 SHALL, for DIVS with dividend = most-negative and divisor = -1, return the dividend; REMS in that case returns 0.
REQ-026 SHALL truncate signed quotients toward zero and give the signed remainder the sign of the dividend.
REQ-027 SHALL, when iCLKEN=0, freeze the state, counter, oQ and oDONE; oDONE stays high across a freeze in DONE.

Reset
REQ-028 SHALL, on inRST low at any time (including mid-operation), asynchronously force state IDLE, oBUSY=0, oDONE=0, oQ=0, and clear the counter and working registers.
REQ-029 SHALL, after inRST deasserts, accept iSTART on the first enabled edge.

Configuration
REQ-030 SHALL, with macro GPPCU_MC_INTU_SIGNED_EN defined, implement MULHS, DIVS and REMS as signed per REQ-023..026.
REQ-031 SHALL, without GPPCU_MC_INTU_SIGNED_EN, execute opcodes 2, 5 and 6 exactly as 1, 3 and 4 respectively, with the sign logic omitted and latency unchanged at BW+2.

Verification (BW=32, iCLKEN=1 unless stated)
REQ-032 SHALL cover: MULLO 7*6 -> oQ=42 with oDONE pulse exactly 34 cycles after start edge, one cycle wide, oBUSY high throughout.
REQ-033 SHALL cover: MULHS 0xFFFFFFFE*3 -> 0xFFFFFFFF; MULHU same operands -> 0x00000002.
REQ-034 SHALL cover: DIVU 100/7 -> 14, REMU 100/7 -> 2; DIVU 5/0 -> 0xFFFFFFFF, REMU 5/0 -> 5.
REQ-035 SHALL cover: DIVS -7/2 -> 0xFFFFFFFD, REMS -7/2 -> 0xFFFFFFFF; DIVS 0x80000000/-1 -> 0x80000000, REMS -> 0; repeated without GPPCU_MC_INTU_SIGNED_EN, DIVS -7/2 -> 0x7FFFFFFC.
REQ-036 SHALL cover: inRST pulsed 10 cycles into a DIVU -> oBUSY=0, oQ=0, no oDONE; a new MULLO 3*3 started next cycle -> 9.
REQ-037 SHALL cover: iSTART re-pulsed with new operands mid-RUN -> ignored, original result delivered; iCLKEN low 5 cycles mid-RUN -> oDONE delayed by exactly 5 cycles.
